// File: rtl/serial_seq_tx.sv
// Serial bit-stream transmitter: accepts a word over valid/ready and shifts it out LSB first,
// with a per-bit valid qualifier, a stall input and a one-cycle done pulse.
module serial_seq_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [LEN_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               ser_q, ser_d;
  logic [LEN_W-1:0]   load_rem;

  // Zero or an over-long length both mean a full-width word.
  always_comb begin
    if ((load_len == '0) || (32'(load_len) > WIDTH)) begin
      load_rem = LEN_W'(WIDTH - 1);
    end else begin
      load_rem = load_len - LEN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    ser_d   = ser_q;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          shift_d = load_data;
          ser_d   = load_data[0];
          idx_d   = '0;
          rem_d   = load_rem;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!hold) begin
          if (rem_q != '0) begin
            shift_d = shift_q >> 1;
            ser_d   = shift_q[1];
            idx_d   = idx_q + LEN_W'(1);
            rem_d   = rem_q - LEN_W'(1);
          end else begin
            ser_d   = 1'b0;
            idx_d   = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
    end
  end

  assign load_ready = (state_q == StIdle);
  assign ser_valid  = (state_q == StShift) && !hold;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign ser_out    = ser_q;
  assign bit_idx    = idx_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Self-checking bench for serial_seq_tx: directed plan steps plus randomized words and stalls,
// each cycle compared against the bit list derived from the word and its effective length.
module tb_serial_seq_tx;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             hold;
  logic             ser_out;
  logic             ser_valid;
  logic [LEN_W-1:0] bit_idx;
  logic             busy;
  logic             done;

  int tests = 0;
  int failed = 0;

  serial_seq_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_len  (load_len),
    .hold      (hold),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > int'(WIDTH)) ? int'(WIDTH) : len;
  endfunction

  // Called and returning at a negedge with the DUT idle. Sends one word and checks every cycle.
  // hold_at/hold_n force a stall of hold_n cycles when bit hold_at is on the line.
  task automatic send_word(input logic [WIDTH-1:0] data, input int len, input int hold_pct,
                           input int hold_at, input int hold_n, input bit keep,
                           input logic [WIDTH-1:0] next_data);
    int n;
    int i;
    int forced;
    int guard;
    n = eff_len(len);
    hold = ($urandom_range(0, 99) < 30);
    #1;
    chk("idle_ready", 32'(load_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(ser_valid), 32'd0);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = LEN_W'(len);
    @(negedge clk);
    load_valid = keep;
    load_data  = next_data;
    i = 0;
    forced = 0;
    guard = 0;
    while (i < n) begin
      if (i == hold_at && forced < hold_n) begin
        hold = 1'b1;
        forced++;
      end else begin
        hold = ($urandom_range(0, 99) < hold_pct);
      end
      #1;
      chk("shift_valid", 32'(ser_valid), 32'(!hold));
      chk("shift_bit", 32'(ser_out), 32'(data[i]));
      chk("shift_idx", 32'(bit_idx), 32'(i));
      chk("shift_ready", 32'(load_ready), 32'd0);
      chk("shift_done", 32'(done), 32'd0);
      if (!hold) i++;
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        chk("shift_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    hold = ($urandom_range(0, 99) < 50);
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(load_ready), 32'd0);
    chk("done_valid", 32'(ser_valid), 32'd0);
    chk("done_ser", 32'(ser_out), 32'd0);
    chk("done_idx", 32'(bit_idx), 32'd0);
    @(negedge clk);
    #1;
    chk("after_done", 32'(done), 32'd0);
    chk("after_ready", 32'(load_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    hold       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ser", 32'(ser_out), 32'd0);
    chk("rst_idx", 32'(bit_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-width word, no stalls.
    send_word(16'hA1C5, 0, 0, -1, 0, 1'b0, '0);
    // Short word and an over-long length.
    send_word(16'h000D, 4, 0, -1, 0, 1'b0, '0);
    send_word(16'hA1C5, 20, 0, -1, 0, 1'b0, '0);
    // Three-cycle stall at bit 5.
    send_word(16'hA1C5, 0, 0, 5, 3, 1'b0, '0);
    // Back-to-back with load_valid held high, alternating words.
    send_word(16'hFFFF, 8, 0, -1, 0, 1'b1, 16'h0000);
    send_word(16'h0000, 8, 0, -1, 0, 1'b1, 16'hFFFF);
    send_word(16'hFFFF, 8, 0, -1, 0, 1'b1, 16'h0000);
    send_word(16'h0000, 8, 0, -1, 0, 1'b0, '0);
    // Single-bit word.
    send_word(16'h0001, 1, 0, -1, 0, 1'b0, '0);

    // Reset in the middle of a word.
    w = 16'hA1C5;
    hold = 1'b0;
    load_valid = 1'b1;
    load_data  = w;
    load_len   = '0;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("pre_rst_idx", 32'(bit_idx), 32'd9);
    chk("pre_rst_bit", 32'(ser_out), 32'(w[9]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(ser_valid), 32'd0);
    chk("post_rst_ser", 32'(ser_out), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_idx", 32'(bit_idx), 32'd0);
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_nodone", 32'(done), 32'd0);
      chk("post_rst_novalid", 32'(ser_valid), 32'd0);
    end
    send_word(16'h8001, 0, 0, -1, 0, 1'b0, '0);

    // Randomized words, lengths and stalls.
    for (int k = 0; k < 40; k++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(0, 31)), 30, -1, 0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
